// File: rtl/prim_rom_pkg.sv
// rtl/prim_rom_pkg.sv - shared types and checksum step for the ROM scanner
package prim_rom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rom_scan_state_e;

  localparam int unsigned RomCsumMaxWidth = 64;

  // Rotate-left-by-one of a width-bit value held in the low bits, then xor in the new word.
  function automatic logic [RomCsumMaxWidth-1:0] rom_csum_step(
    input logic [RomCsumMaxWidth-1:0] csum,
    input logic [RomCsumMaxWidth-1:0] data,
    input int unsigned                width
  );
    logic [RomCsumMaxWidth-1:0] mask;
    logic [RomCsumMaxWidth-1:0] rot;
    mask = (width >= RomCsumMaxWidth) ? '1 : ((64'd1 << width) - 64'd1);
    rot  = ((csum << 1) | (csum >> (width - 1))) & mask;
    return rot ^ (data & mask);
  endfunction

endpackage

// File: rtl/prim_rom_scanner.sv
// rtl/prim_rom_scanner.sv - ROM read scanner with rotate-xor checksum and response protocol check
// Optional checksum compare against exp_checksum_i enabled by ROM_SCAN_CMP_EN.
module prim_rom_scanner
  import prim_rom_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 2048,
  localparam int Aw = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] checksum_o,
  output logic             err_o,
  output logic             req_o,
  output logic [Aw-1:0]    addr_o,
  input  logic             rvalid_i,
  input  logic [Width-1:0] rdata_i,
  input  logic [Width-1:0] exp_checksum_i,
  output logic             mismatch_o
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  rom_scan_state_e  state_q, state_d;
  logic [Aw-1:0]    cnt_q;
  logic [Width-1:0] csum_q;
  logic             pending_q;
  logic             err_q;
  logic             start_acc;
  logic             last_addr;

  assign start_acc = (state_q == IDLE) && start_i;
  assign last_addr = (cnt_q == LastAddr);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SCAN;
      SCAN:    if (last_addr) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      csum_q    <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= (state_q == SCAN);
      if (start_acc) begin
        cnt_q  <= '0;
        csum_q <= '0;
        err_q  <= 1'b0;
      end else begin
        if ((state_q == SCAN) && !last_addr) cnt_q <= cnt_q + 1'b1;
        if (rvalid_i) begin
          csum_q <= Width'(rom_csum_step(64'(csum_q), 64'(rdata_i), Width));
        end
        // Any response that does not line up with the request one cycle earlier is a protocol error.
        if (rvalid_i != pending_q) err_q <= 1'b1;
      end
    end
  end

`ifdef ROM_SCAN_CMP_EN
  logic mismatch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mismatch_q <= 1'b0;
    end else if (start_acc) begin
      mismatch_q <= 1'b0;
    end else if (state_q == DONE) begin
      mismatch_q <= (csum_q != exp_checksum_i);
    end
  end

  assign mismatch_o = mismatch_q;
`else
  logic unused_exp_checksum;
  assign unused_exp_checksum = ^exp_checksum_i;
  assign mismatch_o          = 1'b0;
`endif

  assign req_o      = (state_q == SCAN);
  assign addr_o     = cnt_q;
  assign busy_o     = (state_q == SCAN) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);
  assign checksum_o = csum_q;
  assign err_o      = err_q;

  req_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(req_o));
  addr_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_o |-> (int'(addr_o) < Depth));

endmodule

// File: tb/tb_prim_rom_scanner.sv
// tb/tb_prim_rom_scanner.sv - self-checking bench for prim_rom_scanner (Depth=4 and Depth=1 instances)
module tb_prim_rom_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start4 = 1'b0, busy4, done4, err4, req4, mism4;
  logic        rvalid4 = 1'b0;
  logic [1:0]  addr4;
  logic [31:0] csum4, rdata4 = '0, exp4 = 32'hF;

  logic        start1 = 1'b0, busy1, done1, err1, req1, mism1;
  logic        rvalid1 = 1'b0;
  logic [0:0]  addr1;
  logic [31:0] csum1, rdata1 = '0, exp1 = '0;

  logic [31:0] mem4 [4];
  logic [31:0] mem1 = '0;
  int          drop_addr4 = -1;

  prim_rom_scanner #(.Width(32), .Depth(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .busy_o(busy4), .done_o(done4),
    .checksum_o(csum4), .err_o(err4), .req_o(req4), .addr_o(addr4), .rvalid_i(rvalid4),
    .rdata_i(rdata4), .exp_checksum_i(exp4), .mismatch_o(mism4)
  );

  prim_rom_scanner #(.Width(32), .Depth(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .checksum_o(csum1), .err_o(err1), .req_o(req1), .addr_o(addr1), .rvalid_i(rvalid1),
    .rdata_i(rdata1), .exp_checksum_i(exp1), .mismatch_o(mism1)
  );

  // ROM model: one-cycle response, optional dropped response for one address
  always @(posedge clk) begin
    rvalid4 <= req4 && (int'(addr4) != drop_addr4);
    rdata4  <= mem4[addr4];
    rvalid1 <= req1;
    rdata1  <= mem1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] csum;
    logic        err;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [31:0] w [4];
    int          drop;
    int          extra_start;
    logic [31:0] csum;
    logic        err;
  } vec_t;
  vec_t vecs[6];

  task automatic run4(input vec_t v);
    bit  req_ok, busy_ok, addr_ok;
    int  ndone, done_cyc, err_cyc;
    sb_t e;
    for (int i = 0; i < 4; i++) mem4[i] = v.w[i];
    drop_addr4 = v.drop;
    @(negedge clk);
    start4 = 1'b1;
    sb.push_back('{csum: v.csum, err: v.err});
    @(negedge clk);
    start4 = 1'b0;
    req_ok = 1; busy_ok = 1; addr_ok = 1;
    ndone = 0; done_cyc = -1; err_cyc = -1;
    for (int k = 1; k <= 12; k++) begin
      if (req4 !== (k <= 4)) req_ok = 0;
      if (busy4 !== (k <= 5)) busy_ok = 0;
      if (req4 && (addr4 !== 2'(k - 1))) addr_ok = 0;
      if (err4 && err_cyc < 0) err_cyc = k;
      if (done4) begin
        ndone++;
        done_cyc = k;
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("csum_at_done", csum4, e.csum);
          check("err_at_done", err4, e.err);
        end
      end
      start4 = (k == v.extra_start);
      @(negedge clk);
    end
    start4 = 1'b0;
    check("req_window", req_ok, 1);
    check("busy_window", busy_ok, 1);
    check("addr_sequence", addr_ok, 1);
    check("done_count", ndone, 1);
    check("done_cycle", done_cyc, 6);
    check("err_first_cycle", err_cyc, v.err ? 5 : -1);
    check("csum_held", csum4, v.csum);
    check("sb_drained", sb.size(), 0);
    sb.delete();
`ifdef ROM_SCAN_CMP_EN
    check("mismatch", mism4, (v.csum != exp4));
`else
    check("mismatch_tied", mism4, 0);
`endif
  endtask

  initial begin
    int ndone, done_cyc, req_cnt;
    bit req_ok;

    vecs[0] = '{w: '{32'h1, 32'h1, 32'h1, 32'h1}, drop: -1, extra_start: -1, csum: 32'h0000000F, err: 0};
    vecs[1] = '{w: '{32'h80000000, 32'h0, 32'h0, 32'h0}, drop: -1, extra_start: -1, csum: 32'h00000004, err: 0};
    vecs[2] = '{w: '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, drop: -1, extra_start: -1, csum: 32'hF56DF77E, err: 0};
    vecs[3] = '{w: '{32'h1, 32'h1, 32'h1, 32'h1}, drop: 2, extra_start: -1, csum: 32'h00000007, err: 1};
    vecs[4] = '{w: '{32'h1, 32'h1, 32'h1, 32'h1}, drop: -1, extra_start: 3, csum: 32'h0000000F, err: 0};
    vecs[5] = '{w: '{32'h1, 32'h2, 32'h4, 32'h8}, drop: -1, extra_start: -1, csum: 32'h00000000, err: 0};

    repeat (3) @(negedge clk);
    check("reset_outputs4", {busy4, done4, err4, req4, mism4, addr4, csum4}, '0);
    check("reset_outputs1", {busy1, done1, err1, req1, mism1, addr1, csum1}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run4(vecs[i]);

    // Compare feature: wrong expected value must flag a mismatch after done
    exp4 = 32'hE;
    run4(vecs[0]);
    exp4 = 32'hF;
    run4(vecs[0]);

    // Depth=1: single request in cycle 1, done in cycle 3
    mem1 = 32'hDEADBEEF;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    ndone = 0; done_cyc = -1; req_cnt = 0; req_ok = 1;
    for (int k = 1; k <= 6; k++) begin
      if (req1) req_cnt++;
      if (req1 !== (k == 1)) req_ok = 0;
      if (done1) begin
        ndone++;
        done_cyc = k;
        check("d1_csum_at_done", csum1, 32'hDEADBEEF);
        check("d1_err_at_done", err1, 0);
      end
      @(negedge clk);
    end
    check("d1_req_only_cycle1", req_ok, 1);
    check("d1_req_count", req_cnt, 1);
    check("d1_done_count", ndone, 1);
    check("d1_done_cycle", done_cyc, 3);

    // Reset asserted in cycle 3 of a scan: abandon, no done, then a clean rerun
    for (int i = 0; i < 4; i++) mem4[i] = 32'h1;
    drop_addr4 = -1;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {busy4, done4, err4, req4, mism4, addr4, csum4}, '0);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      if (done4) ndone++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (done4) ndone++;
      @(negedge clk);
    end
    check("midreset_no_done", ndone, 0);
    run4(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
